// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the IF-stage fetch-address generator.
package pc_gen_pkg;

    localparam logic RstEnable   = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam logic NoStop = 1'b0;
    localparam logic Stop   = 1'b1;

    localparam int unsigned DefAddrW       = 32;
    localparam int unsigned DefInc         = 4;
    localparam logic [31:0] DefResetVector = 32'h0;

    typedef enum logic [2:0] {
        SelReset,
        SelFlush,
        SelHold,
        SelBranch,
        SelPend,
        SelSeq
    } pc_sel_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect buffer; a load wins over a clear on the same edge.
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_target,
    output logic              valid,
    output logic [ADDR_W-1:0] target
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            target <= load_target;
        end else if (clear) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator with flush/branch redirect and a pending-redirect buffer.
// Define PC_ALIGN_CHECK_EN to enable the misaligned-fetch check on fetch_misalign.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W       = DefAddrW,
    parameter int unsigned       STALL_W      = 6,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DefResetVector),
    parameter int unsigned       INC          = DefInc
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_pc,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               redirect_pend,
    output logic               fetch_misalign
);

    logic              en_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              if_stall;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic              pend_load;
    logic              pend_clear;
    pc_sel_e           sel;

    // Only the IF bit of the stall vector matters here.
    logic unused_stall;
    assign unused_stall = ^stall[STALL_W-1:1];

    assign if_stall = (stall[0] == Stop);

    always_comb begin
        sel = SelReset;
        if (en_q != ChipEnable) begin
            sel = SelReset;
        end else if (flush) begin
            sel = SelFlush;
        end else if (if_stall) begin
            sel = SelHold;
        end else if (branch_valid) begin
            sel = SelBranch;
        end else if (pend_valid) begin
            sel = SelPend;
        end else begin
            sel = SelSeq;
        end
    end

    always_comb begin
        pc_d = RESET_VECTOR;
        unique case (sel)
            SelReset:  pc_d = RESET_VECTOR;
            SelFlush:  pc_d = flush_pc;
            SelHold:   pc_d = pc_q;
            SelBranch: pc_d = branch_target;
            SelPend:   pc_d = pend_target;
            SelSeq:    pc_d = pc_q + ADDR_W'(INC);
            default:   pc_d = RESET_VECTOR;
        endcase
    end

    // A newer stalled branch simply reloads the entry.
    assign pend_load  = (sel == SelHold) && branch_valid;
    assign pend_clear = (sel == SelFlush) || (sel == SelBranch)
                     || (sel == SelPend);

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .load        (pend_load),
        .clear       (pend_clear),
        .load_target (branch_target),
        .valid       (pend_valid),
        .target      (pend_target)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            en_q <= ChipDisable;
            pc_q <= RESET_VECTOR;
        end else begin
            en_q <= ChipEnable;
            pc_q <= pc_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic mis_q;
    logic mis_d;

    // Sticky until a flush lands on an aligned target.
    always_comb begin
        mis_d = mis_q;
        if (sel == SelFlush) begin
            mis_d = |flush_pc[1:0];
        end else if (sel != SelReset) begin
            mis_d = mis_q | (|pc_d[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign fetch_misalign = mis_q;
    assign ce             = en_q & ~mis_q;
`else
    assign fetch_misalign = 1'b0;
    assign ce             = en_q;
`endif

    assign pc            = pc_q;
    assign redirect_pend = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pend;
    logic        fetch_misalign;

    int checks;
    int failures;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .branch_valid   (branch_valid),
        .branch_target  (branch_target),
        .pc             (pc),
        .ce             (ce),
        .redirect_pend  (redirect_pend),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b0;
        stall         = 6'b0;
        flush         = 1'b0;
        flush_pc      = 32'h0;
        branch_valid  = 1'b0;
        branch_target = 32'h0;

        // reset for 3 edges
        step();
        chk("rst_ce", {31'b0, ce}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        step();
        step();
        chk("rst_ce3", {31'b0, ce}, 32'h0);
        chk("rst_pend", {31'b0, redirect_pend}, 32'h0);
        chk("rst_mis", {31'b0, fetch_misalign}, 32'h0);

        rst = 1'b1;
        step();
        chk("first_ce", {31'b0, ce}, 32'h1);
        chk("first_pc", pc, 32'h0);
        step();
        chk("seq_4", pc, 32'h4);
        step();
        chk("seq_8", pc, 32'h8);
        step();
        chk("seq_c", pc, 32'hC);
        step();
        chk("seq_10", pc, 32'h10);

        // IF stall holds pc
        stall = 6'b000001;
        step();
        chk("stall_1", pc, 32'h10);
        step();
        chk("stall_2", pc, 32'h10);
        step();
        chk("stall_3", pc, 32'h10);
        stall = 6'b0;
        step();
        chk("stall_rel", pc, 32'h14);

        // upper stall bits have no effect
        stall = 6'b111110;
        step();
        chk("hi_stall", pc, 32'h18);
        stall = 6'b0;

        // branch while stalled goes to the buffer
        stall         = 6'b000001;
        branch_valid  = 1'b1;
        branch_target = 32'h200;
        step();
        chk("pend_set", {31'b0, redirect_pend}, 32'h1);
        chk("pend_hold", pc, 32'h18);
        branch_valid = 1'b0;
        step();
        chk("pend_keep", {31'b0, redirect_pend}, 32'h1);
        chk("pend_hold2", pc, 32'h18);
        stall = 6'b0;
        step();
        chk("pend_take", pc, 32'h200);
        chk("pend_clr", {31'b0, redirect_pend}, 32'h0);
        step();
        chk("after_pend", pc, 32'h204);

        // newer stalled branch overwrites older target
        stall         = 6'b000001;
        branch_valid  = 1'b1;
        branch_target = 32'h500;
        step();
        branch_target = 32'h600;
        step();
        branch_valid = 1'b0;
        stall        = 6'b0;
        step();
        chk("overwrite", pc, 32'h600);
        chk("overwrite_clr", {31'b0, redirect_pend}, 32'h0);

        // flush beats branch and stall
        stall         = 6'b000001;
        branch_valid  = 1'b1;
        branch_target = 32'h300;
        flush         = 1'b1;
        flush_pc      = 32'h380;
        step();
        chk("flush_pc", pc, 32'h380);
        chk("flush_pend", {31'b0, redirect_pend}, 32'h0);
        flush        = 1'b0;
        branch_valid = 1'b0;
        stall        = 6'b0;
        step();
        chk("flush_seq", pc, 32'h384);

        // flush discards an existing pending entry
        stall         = 6'b000001;
        branch_valid  = 1'b1;
        branch_target = 32'h700;
        step();
        chk("pend_pre_fl", {31'b0, redirect_pend}, 32'h1);
        branch_valid = 1'b0;
        flush        = 1'b1;
        flush_pc     = 32'h800;
        step();
        chk("fl_over_pend", pc, 32'h800);
        chk("fl_pend_clr", {31'b0, redirect_pend}, 32'h0);
        flush = 1'b0;
        stall = 6'b0;
        step();
        chk("fl_no_pend", pc, 32'h804);

        // unstalled branch
        branch_valid  = 1'b1;
        branch_target = 32'h900;
        step();
        chk("branch", pc, 32'h900);

        // wrap at top of address space
        branch_target = 32'hFFFF_FFFC;
        step();
        chk("top", pc, 32'hFFFF_FFFC);
        branch_valid = 1'b0;
        step();
        chk("wrap", pc, 32'h0);

        // reset during pending redirect
        stall         = 6'b000001;
        branch_valid  = 1'b1;
        branch_target = 32'hA00;
        step();
        chk("pend_pre_rst", {31'b0, redirect_pend}, 32'h1);
        branch_valid = 1'b0;
        rst          = 1'b0;
        step();
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_pend", {31'b0, redirect_pend}, 32'h0);
        chk("mrst_ce", {31'b0, ce}, 32'h0);
        rst      = 1'b1;
        stall    = 6'b0;
        flush    = 1'b1;
        flush_pc = 32'hB00;
        step();
        chk("ce0_ign_fl", pc, 32'h0);
        chk("mrst_ce1", {31'b0, ce}, 32'h1);
        flush = 1'b0;
        step();
        chk("mrst_seq", pc, 32'h4);

        // misaligned branch target
        branch_valid  = 1'b1;
        branch_target = 32'h102;
        step();
        branch_valid = 1'b0;
        chk("mis_pc", pc, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_flag", {31'b0, fetch_misalign}, 32'h1);
        chk("mis_ce", {31'b0, ce}, 32'h0);
        step();
        chk("mis_sticky", {31'b0, fetch_misalign}, 32'h1);
        flush    = 1'b1;
        flush_pc = 32'h400;
        step();
        flush = 1'b0;
        chk("mis_fl_pc", pc, 32'h400);
        chk("mis_fl_flag", {31'b0, fetch_misalign}, 32'h0);
        chk("mis_fl_ce", {31'b0, ce}, 32'h1);
`else
        chk("nomis_flag", {31'b0, fetch_misalign}, 32'h0);
        chk("nomis_ce", {31'b0, ce}, 32'h1);
        step();
        chk("nomis_seq", pc, 32'h106);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
